kfps2kb_cmd_sequencer: RTL and testbench

KFPS2KB_CMD_SEQUENCER -- requirements
Module: kfps2kb_cmd_sequencer

---
 rtl/kfps2kb_pkg.sv | 26 ++
 rtl/kfps2kb_timeout_timer.sv | 26 ++
 rtl/kfps2kb_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_kfps2kb_cmd_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kfps2kb_pkg.sv
// Shared types and PS/2 keyboard command/response bytes for the command sequencer.
package kfps2kb_pkg;

    localparam int unsigned TIMER_W = 24;

    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_ACK,
        WAIT_BAT
    } state_t;

    // Argument byte of the set-LED command: {caps, num, scroll} in the low bits.
    function automatic logic [7:0] led_arg(input logic [2:0] leds);
        return {5'b00000, leds};
    endfunction

endpackage

// File: rtl/kfps2kb_timeout_timer.sv
// Saturating cycle counter; expired is high while enabled and the count has reached limit.
module kfps2kb_timeout_timer
    import kfps2kb_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // Holding at the limit keeps expiry visible if a discarded byte defers it by a cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = enable && (count == limit);

endmodule

// File: rtl/kfps2kb_cmd_sequencer.sv
// Issues LED-update and reset commands to a PS/2 keyboard, handling ACK/RESEND,
// retries, timeouts and the BAT result of a reset.
module kfps2kb_cmd_sequencer
    import kfps2kb_pkg::*;
#(
    parameter logic [15:0] ack_timeout = 16'd2000,
    parameter logic [23:0] bat_timeout = 24'd1000000,
    parameter logic [1:0]  max_retry   = 2'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       led_request,
    input  logic [2:0] led_state,
    input  logic       kbd_reset_request,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       suppress_rx,
    output logic       error,
    output logic       bat_pass
);

    state_t             state;
    logic               pend_led;
    logic               pend_reset;
    logic               seq_reset;
    logic               arg_byte;
    logic [1:0]         retry_cnt;

    logic               rx_ack_c;
    logic               rx_resend_c;
    logic               rx_bat_ok_c;
    logic               rx_bat_fail_c;
    logic               tmr_clear_c;
    logic               tmr_enable_c;
    logic [TIMER_W-1:0] tmr_limit_c;
    logic               tmr_expired;

    assign rx_ack_c      = rx_valid && (rx_data == RSP_ACK);
    assign rx_resend_c   = rx_valid && (rx_data == RSP_RESEND);
    assign rx_bat_ok_c   = rx_valid && (rx_data == RSP_BAT_OK);
    assign rx_bat_fail_c = rx_valid && (rx_data == RSP_BAT_FAIL);

    // One timer serves both waits; it restarts on entry to either wait state.
    always_comb begin
        tmr_enable_c = (state == WAIT_ACK) || (state == WAIT_BAT);
        tmr_clear_c  = !tmr_enable_c || ((state == WAIT_ACK) && rx_ack_c);
        tmr_limit_c  = (state == WAIT_BAT) ? bat_timeout : TIMER_W'(ack_timeout);
    end

    kfps2kb_timeout_timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmr_clear_c),
        .enable  (tmr_enable_c),
        .limit   (tmr_limit_c),
        .expired (tmr_expired)
    );

    assign suppress_rx = busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            error      <= 1'b0;
            bat_pass   <= 1'b0;
            pend_led   <= 1'b0;
            pend_reset <= 1'b0;
            seq_reset  <= 1'b0;
            arg_byte   <= 1'b0;
            retry_cnt  <= 2'd0;
        end else begin
            bat_pass <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Reset outranks LED work and makes any queued LED update redundant.
                    if (kbd_reset_request || pend_reset) begin
                        state      <= SEND;
                        tx_valid   <= 1'b1;
                        tx_data    <= CMD_RESET;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        seq_reset  <= 1'b1;
                        arg_byte   <= 1'b0;
                        retry_cnt  <= 2'd0;
                        pend_reset <= 1'b0;
                        pend_led   <= 1'b0;
                    end else if (led_request || pend_led) begin
                        state     <= SEND;
                        tx_valid  <= 1'b1;
                        tx_data   <= CMD_SET_LED;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        seq_reset <= 1'b0;
                        arg_byte  <= 1'b0;
                        retry_cnt <= 2'd0;
                        pend_led  <= 1'b0;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        state    <= WAIT_TX;
                        tx_valid <= 1'b0;
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A received byte in the expiry cycle takes precedence over the timeout.
                    if (rx_ack_c) begin
                        retry_cnt <= 2'd0;
                        if (seq_reset) begin
                            state <= WAIT_BAT;
                        end else if (!arg_byte) begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= led_arg(led_state);
                            arg_byte <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (rx_resend_c || (!rx_valid && tmr_expired)) begin
                        if (retry_cnt == max_retry) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state     <= SEND;
                            tx_valid  <= 1'b1;
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end
                end
                WAIT_BAT: begin
                    if (rx_bat_ok_c) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bat_pass <= 1'b1;
                    end else if (rx_bat_fail_c || (!rx_valid && tmr_expired)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase

            if (state != IDLE) begin
                if (led_request) begin
                    pend_led <= 1'b1;
                end
                if (kbd_reset_request) begin
                    pend_reset <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kfps2kb_cmd_sequencer.sv
// Self-checking bench: plays transmit engine and keyboard, predicts each transaction
// from retry/timeout rules, and mixes directed scenarios with randomized traffic.
module tb_kfps2kb_cmd_sequencer;
    import kfps2kb_pkg::*;

    localparam int ACK_TO    = 20;
    localparam int BAT_TO    = 60;
    localparam int MAX_RETRY = 3;

    localparam int R_ACK = 0, R_RESEND = 1, R_SILENT = 2, R_NOISE_ACK = 3, R_LATE_ACK = 4;
    localparam int B_PASS = 0, B_FAIL = 1, B_NOISE = 2, B_SILENT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       led_request;
    logic [2:0] led_state;
    logic       kbd_reset_request;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       suppress_rx;
    logic       error;
    logic       bat_pass;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sent  = 0;
    bit abort   = 1'b0;
    bit exp_err = 1'b0;
    bit hold_led = 1'b0;
    int script[$];

    kfps2kb_cmd_sequencer #(
        .ack_timeout (16'(ACK_TO)),
        .bat_timeout (24'(BAT_TO)),
        .max_retry   (2'(MAX_RETRY))
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .led_request       (led_request),
        .led_state         (led_state),
        .kbd_reset_request (kbd_reset_request),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .tx_done           (tx_done),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .busy              (busy),
        .suppress_rx       (suppress_rx),
        .error             (error),
        .bat_pass          (bat_pass)
    );

    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d failed so far", n_fail, n_tests);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] noise_byte();
        return 8'($urandom_range(0, 8'h9F));
    endfunction

    function automatic int next_code();
        int r;
        if (script.size() > 0) return script.pop_front();
        r = $urandom_range(0, 11);
        if (r <= 5) return R_ACK;
        if (r == 6 || r == 7 || r == 11) return R_RESEND;
        if (r == 8) return R_SILENT;
        if (r == 9) return R_NOISE_ACK;
        return R_LATE_ACK;
    endfunction

    task automatic hw_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        abort = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic reply(input logic [7:0] b);
        repeat ($urandom_range(0, 4)) tick();
        rx_pulse(b);
    endtask

    // Transmit engine: wait for the offer, stall randomly, accept, then report completion.
    task automatic expect_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_valid && n < 40) begin
            tick();
            n++;
        end
        if (!tx_valid) begin
            check("tx_valid_wait", tx_valid, 1);
            abort = 1'b1;
            return;
        end
        if (!hold_led) led_state = 3'($urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) tick();
        check("tx_valid_hold", tx_valid, 1);
        check("tx_data", tx_data, b);
        n_sent++;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_valid_drop", tx_valid, 0);
        repeat ($urandom_range(0, 3)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // One command byte with keyboard replies; more than MAX_RETRY resends means failure.
    task automatic run_byte(input logic [7:0] b);
        int retries = 0;
        int code;
        bit done = 1'b0;
        while (!done) begin
            expect_tx(b);
            if (abort) return;
            code = next_code();
            case (code)
                R_RESEND: begin
                    reply(RSP_RESEND);
                    retries++;
                end
                R_SILENT: begin
                    repeat (ACK_TO) tick();
                    check("ack_wait_quiet", tx_valid, 0);
                    tick();
                    retries++;
                end
                R_NOISE_ACK: begin
                    reply(noise_byte());
                    reply(RSP_ACK);
                    done = 1'b1;
                end
                R_LATE_ACK: begin
                    repeat (ACK_TO) tick();
                    check("late_ack_quiet", tx_valid, 0);
                    rx_pulse(RSP_ACK);
                    done = 1'b1;
                end
                default: begin
                    reply(RSP_ACK);
                    done = 1'b1;
                end
            endcase
            if (!done) begin
                if (retries > MAX_RETRY) begin
                    exp_err = 1'b1;
                    check("retry_err", error, 1);
                    check("retry_idle", busy, 0);
                    check("retry_no_tx", tx_valid, 0);
                    return;
                end
                check("resend_latency", tx_valid, 1);
            end
        end
    endtask

    task automatic start_req(input bit want_reset, input bit want_led);
        exp_err = 1'b0;
        kbd_reset_request = want_reset;
        led_request = want_led;
        tick();
        kbd_reset_request = 1'b0;
        led_request = 1'b0;
        check("accept_valid", tx_valid, 1);
        check("accept_busy", busy, 1);
        check("accept_suppress", suppress_rx, 1);
        check("accept_err_clear", error, 0);
        check("accept_byte", tx_data, want_reset ? CMD_RESET : CMD_SET_LED);
    endtask

    task automatic do_led_op();
        logic [7:0] arg;
        start_req(1'b0, 1'b1);
        run_byte(CMD_SET_LED);
        if (abort || exp_err) return;
        arg = {5'b00000, led_state};
        run_byte(arg);
        if (abort || exp_err) return;
        check("led_done_busy", busy, 0);
        check("led_done_err", error, 0);
    endtask

    task automatic bat_ok();
        reply(RSP_BAT_OK);
        check("bat_pass_pulse", bat_pass, 1);
        check("bat_pass_idle", busy, 0);
        check("bat_pass_err", error, 0);
        tick();
        check("bat_pass_width", bat_pass, 0);
    endtask

    task automatic reset_tail(input int code);
        run_byte(CMD_RESET);
        if (abort || exp_err) return;
        check("bat_wait_busy", busy, 1);
        case (code)
            B_FAIL: begin
                reply(RSP_BAT_FAIL);
                exp_err = 1'b1;
                check("bat_fail_err", error, 1);
                check("bat_fail_idle", busy, 0);
                check("bat_fail_nopass", bat_pass, 0);
            end
            B_SILENT: begin
                repeat (BAT_TO) tick();
                check("bat_quiet_busy", busy, 1);
                check("bat_quiet_err", error, 0);
                tick();
                exp_err = 1'b1;
                check("bat_timeout_err", error, 1);
                check("bat_timeout_idle", busy, 0);
            end
            B_NOISE: begin
                reply(noise_byte());
                check("bat_noise_busy", busy, 1);
                bat_ok();
            end
            default: bat_ok();
        endcase
    endtask

    initial begin
        int sent0;
        reset = 1'b1;
        led_request = 1'b0;
        kbd_reset_request = 1'b0;
        led_state = 3'b000;
        tx_ready = 1'b0;
        tx_done = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tick();
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_suppress", suppress_rx, 0);
        check("rst_error", error, 0);
        check("rst_bat_pass", bat_pass, 0);
        reset = 1'b0;
        tick();

        // LED update with fixed state, every byte acknowledged
        hold_led = 1'b1;
        led_state = 3'b101;
        script = '{R_ACK, R_ACK};
        start_req(1'b0, 1'b1);
        run_byte(CMD_SET_LED);
        run_byte(8'h05);
        check("led101_busy", busy, 0);
        check("led101_err", error, 0);
        hold_led = 1'b0;

        // Reset with BAT pass, then BAT failure
        script = '{R_ACK};
        start_req(1'b1, 1'b0);
        reset_tail(B_PASS);
        script = '{R_ACK};
        start_req(1'b1, 1'b0);
        reset_tail(B_FAIL);
        repeat (3) tick();
        check("err_sticky", error, 1);

        // Three resends then ACK, then four resends
        sent0 = n_sent;
        script = '{R_RESEND, R_RESEND, R_RESEND, R_ACK, R_ACK};
        do_led_op();
        check("resend3_sends", n_sent - sent0, 5);
        sent0 = n_sent;
        script = '{R_RESEND, R_RESEND, R_RESEND, R_RESEND};
        do_led_op();
        check("resend4_sends", n_sent - sent0, 4);
        check("resend4_exp_err", error, 1);

        // Silent keyboard: timed resend, then permanent silence
        sent0 = n_sent;
        script = '{R_SILENT, R_ACK, R_ACK};
        do_led_op();
        check("silent1_sends", n_sent - sent0, 3);
        sent0 = n_sent;
        script = '{R_SILENT, R_SILENT, R_SILENT, R_SILENT};
        do_led_op();
        check("silent4_sends", n_sent - sent0, 4);

        // ACK arriving exactly in the expiry cycle is accepted
        script = '{R_LATE_ACK, R_LATE_ACK};
        do_led_op();

        // Requests during a busy LED sequence: reset runs next, duplicate LED dropped
        script = '{R_ACK, R_ACK, R_ACK};
        start_req(1'b0, 1'b1);
        led_request = 1'b1;
        tick();
        led_request = 1'b0;
        kbd_reset_request = 1'b1;
        tick();
        kbd_reset_request = 1'b0;
        led_request = 1'b1;
        tick();
        led_request = 1'b0;
        run_byte(CMD_SET_LED);
        run_byte({5'b00000, led_state});
        check("pend_idle_gap", busy, 0);
        tick();
        check("pend_reset_valid", tx_valid, 1);
        check("pend_reset_byte", tx_data, CMD_RESET);
        reset_tail(B_PASS);
        repeat (10) tick();
        check("pend_no_led_valid", tx_valid, 0);
        check("pend_no_led_busy", busy, 0);

        // Reset while waiting for tx_done
        start_req(1'b0, 1'b1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("wtx_busy", busy, 1);
        reset = 1'b1;
        led_request = 1'b1;
        tick();
        reset = 1'b0;
        led_request = 1'b0;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_suppress", suppress_rx, 0);
        check("midrst_error", error, 0);
        tick();
        check("midrst_req_ignored", tx_valid, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        rx_pulse(RSP_ACK);
        check("midrst_still_idle", busy, 0);
        check("midrst_no_tx", tx_valid, 0);
        do_led_op();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                do_led_op();
            end else begin
                start_req(1'b1, op == 3);
                reset_tail($urandom_range(0, 3));
            end
            if (abort) hw_reset();
            repeat ($urandom_range(0, 3)) tick();
            check("gap_busy", busy, 0);
            check("gap_error", error, exp_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
